// File: rtl/hcm_rmw_engine.sv
`default_nettype none
// ============================================================================
// Module  : hcm_rmw_engine
// Brief   : Hit count memory read-modify-write engine with tagged forwarding.
//           Optional clear sweep enabled by defining HCM_CLEAR_SWEEP_EN.
// Revision: 1.0
// ============================================================================
module hcm_rmw_engine #(
    parameter int ROW_BITS  = 10,
    parameter int NHIT_BITS = 3,
    parameter int ADDR_BITS = 8,
    parameter int INFO_BITS = 16,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [ROW_BITS-1:0]  upd_row,
    input  logic                 upd_is_new,
    input  logic [INFO_BITS-1:0] upd_info,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ROW_BITS-1:0]  rd_row,
    input  logic                 clear_start,
    output logic                 out_valid,
    output logic                 out_is_update,
    output logic [ROW_BITS-1:0]  out_row,
    output logic [NHIT_BITS-1:0] out_old_n,
    output logic [NHIT_BITS-1:0] out_new_n,
    output logic [ADDR_BITS-1:0] out_him_addr,
    output logic [INFO_BITS-1:0] out_info,
    output logic                 out_sat,
    output logic                 out_overflow,
    output logic                 alloc_full,
    output logic                 busy
);
    localparam int c_WORD_BITS = ADDR_BITS + NHIT_BITS;
    localparam int c_DEPTH     = 1 << ROW_BITS;
    localparam logic [NHIT_BITS-1:0] c_MAX_N = {NHIT_BITS{1'b1}};

    logic [c_WORD_BITS-1:0] r_mem   [c_DEPTH];
    logic [c_WORD_BITS-1:0] r_ramQ  [RD_LAT];
    logic [RD_LAT-1:0]      r_pValid;
    logic [RD_LAT-1:0]      r_pUpd;
    logic [RD_LAT-1:0]      r_pNew;
    logic [ROW_BITS-1:0]    r_pRow  [RD_LAT];
    logic [INFO_BITS-1:0]   r_pInfo [RD_LAT];
    logic [RD_LAT-1:0]      r_hValid;
    logic [ROW_BITS-1:0]    r_hRow  [RD_LAT];
    logic [c_WORD_BITS-1:0] r_hWord [RD_LAT];
    logic [ADDR_BITS:0]     r_nextAddr;

    logic                   w_idle;
    logic                   w_sweepWe;
    logic [ROW_BITS-1:0]    w_sweepRow;
    logic                   w_accUpd;
    logic                   w_acc;
    logic [ROW_BITS-1:0]    w_rdRow;
    logic [c_WORD_BITS-1:0] w_base;
    logic [NHIT_BITS-1:0]   w_oldN;
    logic [NHIT_BITS-1:0]   w_newN;
    logic [ADDR_BITS-1:0]   w_addr;
    logic                   w_sat;
    logic                   w_ovf;
    logic                   w_wr;
    logic                   w_modWe;
    logic                   w_memWe;
    logic [ROW_BITS-1:0]    w_memAddr;
    logic [c_WORD_BITS-1:0] w_memData;

`ifdef HCM_CLEAR_SWEEP_EN
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAIN = 2'd1;
    localparam logic [1:0] c_SWEEP = 2'd2;

    logic [1:0]          r_state;
    logic [ROW_BITS-1:0] r_sweepRow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_sweepRow <= '0;
        end else begin
            case (r_state)
                c_IDLE:  if (clear_start) r_state <= c_DRAIN;
                c_DRAIN: begin
                    if (r_pValid == '0) begin
                        r_state    <= c_SWEEP;
                        r_sweepRow <= '0;
                    end
                end
                c_SWEEP: begin
                    r_sweepRow <= r_sweepRow + 1'b1;
                    if (&r_sweepRow) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign w_idle     = (r_state == c_IDLE);
    assign w_sweepWe  = (r_state == c_SWEEP);
    assign w_sweepRow = r_sweepRow;
`else
    logic w_unusedClear;
    assign w_unusedClear = clear_start;
    assign w_idle        = 1'b1;
    assign w_sweepWe     = 1'b0;
    assign w_sweepRow    = '0;
`endif

    // Update has priority; a lookup is only taken when no update is offered.
    assign upd_ready = w_idle;
    assign rd_ready  = w_idle && !upd_valid;
    assign w_accUpd  = upd_valid && upd_ready;
    assign w_acc     = w_accUpd || (rd_valid && rd_ready);
    assign w_rdRow   = upd_valid ? upd_row : rd_row;

    assign alloc_full = r_nextAddr[ADDR_BITS];
    assign busy       = (|r_pValid) || !w_idle;

    // Scan oldest to youngest so the most recent matching write wins.
    always_comb begin
        w_base = r_ramQ[RD_LAT-1];
        for (int k = RD_LAT - 1; k >= 0; k--) begin
            if (r_hValid[k] && (r_hRow[k] == r_pRow[RD_LAT-1])) w_base = r_hWord[k];
        end
        w_oldN = w_base[NHIT_BITS-1:0];
        w_newN = w_base[NHIT_BITS-1:0];
        w_addr = w_base[c_WORD_BITS-1:NHIT_BITS];
        w_sat  = 1'b0;
        w_ovf  = 1'b0;
        w_wr   = 1'b0;
        if (r_pUpd[RD_LAT-1]) begin
            if (r_pNew[RD_LAT-1]) begin
                w_oldN = '0;
                w_newN = NHIT_BITS'(1);
                if (alloc_full) begin
                    w_addr = '0;
                    w_ovf  = 1'b1;
                end else begin
                    w_addr = r_nextAddr[ADDR_BITS-1:0];
                    w_wr   = 1'b1;
                end
            end else begin
                w_wr = 1'b1;
                if (w_oldN == c_MAX_N) w_sat = 1'b1;
                else                   w_newN = w_oldN + 1'b1;
            end
        end
    end

    assign w_modWe   = r_pValid[RD_LAT-1] && w_wr;
    assign w_memWe   = !reset && (w_modWe || w_sweepWe);
    assign w_memAddr = w_sweepWe ? w_sweepRow : r_pRow[RD_LAT-1];
    assign w_memData = w_sweepWe ? '0 : {w_addr, w_newN};

    // RAM and data-path registers carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_memWe) r_mem[w_memAddr] <= w_memData;
        r_ramQ[0]  <= r_mem[w_rdRow];
        r_pRow[0]  <= w_rdRow;
        r_pUpd[0]  <= w_accUpd;
        r_pNew[0]  <= w_accUpd && upd_is_new;
        r_pInfo[0] <= w_accUpd ? upd_info : '0;
        for (int k = RD_LAT - 1; k >= 1; k--) begin
            r_ramQ[k]  <= r_ramQ[k-1];
            r_pRow[k]  <= r_pRow[k-1];
            r_pUpd[k]  <= r_pUpd[k-1];
            r_pNew[k]  <= r_pNew[k-1];
            r_pInfo[k] <= r_pInfo[k-1];
        end
        if (w_modWe) begin
            r_hRow[0]  <= r_pRow[RD_LAT-1];
            r_hWord[0] <= w_memData;
            for (int k = RD_LAT - 1; k >= 1; k--) begin
                r_hRow[k]  <= r_hRow[k-1];
                r_hWord[k] <= r_hWord[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pValid   <= '0;
            r_hValid   <= '0;
            r_nextAddr <= '0;
        end else begin
            r_pValid[0] <= w_acc;
            for (int k = RD_LAT - 1; k >= 1; k--) r_pValid[k] <= r_pValid[k-1];
            if (w_sweepWe) begin
                r_hValid   <= '0;
                r_nextAddr <= '0;
            end else if (w_modWe) begin
                r_hValid[0] <= 1'b1;
                for (int k = RD_LAT - 1; k >= 1; k--) r_hValid[k] <= r_hValid[k-1];
                if (r_pNew[RD_LAT-1]) r_nextAddr <= r_nextAddr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_is_update <= 1'b0;
            out_row       <= '0;
            out_old_n     <= '0;
            out_new_n     <= '0;
            out_him_addr  <= '0;
            out_info      <= '0;
            out_sat       <= 1'b0;
            out_overflow  <= 1'b0;
        end else begin
            out_valid <= r_pValid[RD_LAT-1];
            if (r_pValid[RD_LAT-1]) begin
                out_is_update <= r_pUpd[RD_LAT-1];
                out_row       <= r_pRow[RD_LAT-1];
                out_old_n     <= w_oldN;
                out_new_n     <= w_newN;
                out_him_addr  <= w_addr;
                out_info      <= r_pInfo[RD_LAT-1];
                out_sat       <= w_sat;
                out_overflow  <= w_ovf;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_hcm_rmw_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_hcm_rmw_engine
// Brief   : Directed, table-driven bench for hcm_rmw_engine (default widths).
// Revision: 1.0
// ============================================================================
module tb_hcm_rmw_engine;
    localparam int RD_LAT = 2;

    typedef struct {
        logic        isUpd;
        logic        isNew;
        logic [9:0]  row;
        logic [15:0] info;
        logic [2:0]  expOld;
        logic [2:0]  expNew;
        logic [7:0]  expAddr;
        logic        expSat;
        logic        expOvf;
        int          gap;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [9:0]  upd_row;
    logic        upd_is_new;
    logic [15:0] upd_info;
    logic        rd_valid;
    logic        rd_ready;
    logic [9:0]  rd_row;
    logic        clear_start;
    logic        out_valid;
    logic        out_is_update;
    logic [9:0]  out_row;
    logic [2:0]  out_old_n;
    logic [2:0]  out_new_n;
    logic [7:0]  out_him_addr;
    logic [15:0] out_info;
    logic        out_sat;
    logic        out_overflow;
    logic        alloc_full;
    logic        busy;

    int total = 0;
    int bad   = 0;
    vec_t tab [13];
    vec_t bq  [8];
    int   nb;

    hcm_rmw_engine #(
        .ROW_BITS(10), .NHIT_BITS(3), .ADDR_BITS(8), .INFO_BITS(16), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row),
        .upd_is_new(upd_is_new), .upd_info(upd_info),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_row(rd_row),
        .clear_start(clear_start),
        .out_valid(out_valid), .out_is_update(out_is_update), .out_row(out_row),
        .out_old_n(out_old_n), .out_new_n(out_new_n), .out_him_addr(out_him_addr),
        .out_info(out_info), .out_sat(out_sat), .out_overflow(out_overflow),
        .alloc_full(alloc_full), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mkv(input logic u, input logic n, input int row, input int info,
                                 input int eo, input int en, input int ea,
                                 input logic s, input logic o, input int gap);
        vec_t v;
        v.isUpd = u; v.isNew = n; v.row = 10'(row); v.info = 16'(info);
        v.expOld = 3'(eo); v.expNew = 3'(en); v.expAddr = 8'(ea);
        v.expSat = s; v.expOvf = o; v.gap = gap;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idleIn();
        upd_valid = 1'b0; rd_valid = 1'b0; upd_is_new = 1'b0;
    endtask

    task automatic drive(input vec_t v, input string tag);
        upd_valid  = v.isUpd;
        upd_is_new = v.isNew;
        upd_row    = v.row;
        upd_info   = v.isUpd ? v.info : 16'hDEAD;
        rd_valid   = !v.isUpd;
        rd_row     = v.row;
        #1;
        chk({tag, ".ready"}, v.isUpd ? upd_ready : rd_ready, 1);
    endtask

    task automatic checkOut(input vec_t v, input string tag);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".isupd"}, out_is_update, v.isUpd);
        chk({tag, ".row"},   out_row, v.row);
        chk({tag, ".old"},   out_old_n, v.expOld);
        chk({tag, ".new"},   out_new_n, v.expNew);
        chk({tag, ".addr"},  out_him_addr, v.expAddr);
        chk({tag, ".info"},  out_info, v.isUpd ? v.info : 16'h0);
        chk({tag, ".sat"},   out_sat, v.expSat);
        chk({tag, ".ovf"},   out_overflow, v.expOvf);
    endtask

    // Single op: drive, accept, then wait (bounded) for its result strobe.
    task automatic singleOp(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        drive(v, tag);
        @(posedge clk);
        #1;
        idleIn();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".lat"}, lat, RD_LAT + 1);
        checkOut(v, tag);
    endtask

    // Back-to-back ops, one per cycle; results must follow on consecutive cycles.
    task automatic runBurst(input string nm);
        for (int c = 0; c <= nb + RD_LAT; c++) begin
            @(negedge clk);
            if (c >= RD_LAT + 1) checkOut(bq[c-RD_LAT-1], $sformatf("%s%0d", nm, c - RD_LAT - 1));
            if (c < nb) drive(bq[c], $sformatf("%s%0d", nm, c));
            else        idleIn();
        end
    endtask

    initial begin
        int   seen;
        vec_t v;

        tab[0]  = mkv(1, 1, 5,   'h1111, 0, 1, 0, 0, 0, 0);
        tab[1]  = mkv(1, 0, 5,   'h2222, 1, 2, 0, 0, 0, 10);
        tab[2]  = mkv(0, 0, 5,   0,      2, 2, 0, 0, 0, 1);
        tab[3]  = mkv(1, 1, 9,   'h0901, 0, 1, 1, 0, 0, 1);
        tab[4]  = mkv(1, 0, 9,   'h0902, 1, 2, 1, 0, 0, 1);
        tab[5]  = mkv(1, 0, 9,   'h0903, 2, 3, 1, 0, 0, 1);
        tab[6]  = mkv(1, 0, 9,   'h0904, 3, 4, 1, 0, 0, 1);
        tab[7]  = mkv(1, 0, 9,   'h0905, 4, 5, 1, 0, 0, 1);
        tab[8]  = mkv(1, 0, 9,   'h0906, 5, 6, 1, 0, 0, 1);
        tab[9]  = mkv(1, 0, 9,   'h0907, 6, 7, 1, 0, 0, 1);
        tab[10] = mkv(1, 0, 9,   'h0908, 7, 7, 1, 1, 0, 1);
        tab[11] = mkv(0, 0, 9,   0,      7, 7, 1, 0, 0, 1);
        tab[12] = mkv(0, 0, 100, 0,      0, 0, 0, 0, 0, 1);

        reset = 1'b1; clear_start = 1'b0;
        upd_row = '0; upd_info = '0; rd_row = '0;
        idleIn();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.valid", out_valid, 0);
        chk("rst.isupd", out_is_update, 0);
        chk("rst.row",   out_row, 0);
        chk("rst.new",   out_new_n, 0);
        chk("rst.addr",  out_him_addr, 0);
        chk("rst.info",  out_info, 0);
        chk("rst.flags", {out_sat, out_overflow, alloc_full, busy}, 0);
        chk("rst.ready", {upd_ready, rd_ready}, 2'b11);

        for (int i = 0; i < 13; i++) begin
            repeat (tab[i].gap) @(negedge clk);
            singleOp(tab[i], $sformatf("v%0d", i));
            @(negedge clk);
            chk($sformatf("v%0d.strobe", i), out_valid, 0);
            chk($sformatf("v%0d.hold", i), out_new_n, tab[i].expNew);
        end

        // Same-row updates in consecutive cycles depend entirely on forwarding.
        nb = 5;
        bq[0] = mkv(1, 1, 7, 'h0701, 0, 1, 2, 0, 0, 0);
        bq[1] = mkv(1, 0, 7, 'h0702, 1, 2, 2, 0, 0, 0);
        bq[2] = mkv(1, 0, 7, 'h0703, 2, 3, 2, 0, 0, 0);
        bq[3] = mkv(1, 0, 7, 'h0704, 3, 4, 2, 0, 0, 0);
        bq[4] = mkv(0, 0, 7, 0,      4, 4, 2, 0, 0, 0);
        runBurst("b7_");
        repeat (3) @(negedge clk);
        singleOp(mkv(0, 0, 7, 0, 4, 4, 2, 0, 0, 0), "b7_late");

        // Update and lookup offered together: update first, lookup next cycle.
        @(negedge clk);
        upd_valid = 1'b1; upd_is_new = 1'b1; upd_row = 10'd20; upd_info = 16'hABCD;
        rd_valid = 1'b1; rd_row = 10'd5;
        #1;
        chk("sim.rd_ready", rd_ready, 0);
        chk("sim.upd_ready", upd_ready, 1);
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        chk("sim.rd_ready2", rd_ready, 1);
        @(negedge clk);
        idleIn();
        @(negedge clk);
        checkOut(mkv(1, 1, 20, 'hABCD, 0, 1, 3, 0, 0, 0), "simU");
        @(negedge clk);
        checkOut(mkv(0, 0, 5, 0, 2, 2, 0, 0, 0, 0), "simR");

        // Interleaved rows exercise both history slots.
        repeat (3) @(negedge clk);
        nb = 5;
        bq[0] = mkv(1, 1, 11, 'h0B01, 0, 1, 4, 0, 0, 0);
        bq[1] = mkv(1, 1, 12, 'h0C01, 0, 1, 5, 0, 0, 0);
        bq[2] = mkv(1, 0, 11, 'h0B02, 1, 2, 4, 0, 0, 0);
        bq[3] = mkv(0, 0, 12, 0,      1, 1, 5, 0, 0, 0);
        bq[4] = mkv(0, 0, 11, 0,      2, 2, 4, 0, 0, 0);
        runBurst("bx_");

        // Reset while an update to row 3 is in flight.
        repeat (3) @(negedge clk);
        @(negedge clk);
        drive(mkv(1, 0, 3, 'h0301, 1, 1, 0, 0, 0, 0), "rf");
        @(posedge clk);
        #1;
        idleIn();
        seen = 0;
        @(negedge clk);
        seen += int'(out_valid);
        @(negedge clk);
        seen += int'(out_valid);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("rf.no_out", seen, 0);
        chk("rf.state", {busy, alloc_full, upd_ready, rd_ready}, 4'b0011);
        singleOp(mkv(0, 0, 3, 0, 0, 0, 0, 0, 0, 0), "rf_look");

        // Exhaust the allocator: addresses restart at 0 after reset.
        for (int i = 0; i < 256; i++) begin
            singleOp(mkv(1, 1, 600 + i, i, 0, 1, i, 0, 0, 0), $sformatf("al%0d", i));
            if (i == 254) chk("al.notfull", alloc_full, 0);
        end
        chk("al.full", alloc_full, 1);
        singleOp(mkv(1, 1, 1000, 'h0FFF, 0, 1, 0, 0, 1, 0), "al_ovf");
        chk("al.full2", alloc_full, 1);
        singleOp(mkv(0, 0, 1000, 0, 0, 0, 0, 0, 0, 0), "al_look");
        singleOp(mkv(0, 0, 855, 0, 1, 1, 255, 0, 0, 0), "al_last");

`ifdef HCM_CLEAR_SWEEP_EN
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        chk("clr.ready", upd_ready, 0);
        seen = 0;
        while (busy && seen < 5000) begin
            @(negedge clk);
            seen++;
        end
        chk("clr.long", int'(seen >= 1023 && seen < 5000), 1);
        chk("clr.full", alloc_full, 0);
        singleOp(mkv(0, 0, 5, 0, 0, 0, 0, 0, 0, 0), "clr_r5");
        singleOp(mkv(0, 0, 855, 0, 0, 0, 0, 0, 0, 0), "clr_r855");
        singleOp(mkv(1, 1, 50, 'h5050, 0, 1, 0, 0, 0, 0), "clr_new");
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hcm_rmw_engine.md
# hcm_rmw_engine

Parametrised hit count memory (HCM) engine for the pattern-matching front end. It keeps a per-SSID-row word of {HIM base address, hit count} in an internal dual-port block RAM. It accepts one update (add one hit) or one lookup per cycle, and returns old/new counts plus the HIM address after a fixed latency. Read-after-write hazards inside the RAM read window are resolved by a tagged forwarding history rather than by row perturbation. The RAM latency, row/count/address widths and forwarding depth are all parameters.

## Interface
- ROW_BITS, 10, HCM row index width; RAM depth is 2^ROW_BITS
- NHIT_BITS, 3, hit count field width; the count saturates at 2^NHIT_BITS-1
- ADDR_BITS, 8, HIM base address field width; RAM word is ADDR_BITS+NHIT_BITS, with the address in the MSBs
- INFO_BITS, 16, opaque hit-info payload carried alongside each op
- RD_LAT, 2, RAM read latency in cycles (>=1); also the forwarding history depth
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- upd_valid / upd_ready  in / out  1  update handshake
- upd_row  in  ROW_BITS  row to increment
- upd_is_new  in  1  row is a first-seen SSID; allocate a HIM address
- upd_info  in  INFO_BITS  payload
- rd_valid / rd_ready  in / out  1  lookup handshake
- rd_row  in  ROW_BITS  row to look up
- clear_start  in  1  request an HCM clear sweep (see Configuration)
- out_valid  out  1  one-cycle result strobe
- out_is_update  out  1  1 = update result, 0 = lookup result
- out_row  out  ROW_BITS
- out_old_n / out_new_n  out  NHIT_BITS  count before / after the op
- out_him_addr  out  ADDR_BITS
- out_info  out  INFO_BITS  payload of the op (0 for lookups)
- out_sat  out  1  the increment was clipped at the maximum count
- out_overflow  out  1  a new-SSID op found the allocator exhausted
- alloc_full  out  1  level signal; all 2^ADDR_BITS addresses are used
- busy  out  1  pipeline non-empty or clear in progress

## Operation
- One op per cycle. If both handshakes are valid in the same cycle, the update wins; rd_ready = idle && !upd_valid, upd_ready = idle.
- Accepted op: the row is presented to the RAM read port the same cycle and tagged {type, row, is_new, info} down a RD_LAT-deep pipe.
- Modify stage (RD_LAT cycles after accept):
  - base = the youngest matching entry in the forward history (last RD_LAT writes: row, word, valid), else RAM data.
  - Lookup: old_n = new_n = base.n; address = base.addr; no write.
  - Update with is_new=0: new_n = min(base.n+1, max); out_sat is set when base.n == max; the address is kept; the word is written.
  - Update with is_new=1: base is ignored; old_n = 0, new_n = 1, address = next_addr; next_addr increments.
  - If next_addr has reached 2^ADDR_BITS (the counter is ADDR_BITS+1 wide): no write, out_overflow=1, address reported as 0, next_addr unchanged.
- Each write pushes {row, word} into the history. Writes use RAM port A; reads use port B.
- Results are returned strictly in accept order.
- RAM contents are not cleared by reset.
- Reset mid-flight: all in-flight ops are dropped, with no write and no out_valid. next_addr and history valids clear; the clear FSM returns to IDLE.

## Timing
- Accept at edge t: modify and RAM write at cycle t+RD_LAT; out_* is registered and valid at t+RD_LAT+1 for exactly one cycle.
- Throughput is 1 op/cycle; back-to-back same-row updates give consecutive counts with no bubble.
- A write at cycle w is visible via RAM to reads issued at w+1 or later. Ops issued in (w-RD_LAT, w] obtain it via forwarding.
- Reset values:
  - all outputs are 0, except upd_ready = rd_ready = 1 in the cycle after reset deasserts;
  - busy = 0, alloc_full = 0.
- out_* hold their last values when out_valid = 0.

## Configuration
- HCM_CLEAR_SWEEP_EN defined:
  - clear_start sampled high in IDLE moves the FSM IDLE->DRAIN. DRAIN drops both readies and waits for the pipe to empty.
  - SWEEP writes 0 to rows 0..2^ROW_BITS-1, one per cycle, then returns to IDLE. It also clears next_addr, alloc_full and the history.
  - busy is high throughout. The sweep takes 2^ROW_BITS cycles plus drain time.
- Not defined: clear_start is ignored, the FSM is absent, and the readies depend only on upd_valid.

## Test plan
- After reset: update row 5 with is_new=1 -> out old 0, new 1, addr 0. Ten cycles later, update row 5 with is_new=0 -> old 1, new 2, addr 0. Then look up row 5 -> new_n 2, out_is_update 0.
- Four back-to-back updates to row 7 (first is_new=1), RD_LAT=2 and RD_LAT=3 -> new_n 1,2,3,4 on four consecutive out_valid cycles; a later lookup returns 4.
- NHIT_BITS=3, eight updates to row 9 -> the 8th gives old 7, new 7, out_sat=1.
- ADDR_BITS=2, five is_new updates to rows 1..5 -> addrs 0,1,2,3; the 5th gives out_overflow=1 and alloc_full=1, and a lookup of row 5 returns 0/0.
- upd_valid and rd_valid asserted together -> rd_ready=0 and only the update is accepted; the lookup is accepted the next cycle.
- Reset asserted two cycles after an update to row 3 -> no out_valid; a lookup of row 3 returns 0. With HCM_CLEAR_SWEEP_EN and ROW_BITS=4: clear_start -> busy for at least 16 cycles, after which all rows read 0 and the next new row gets addr 0.
